// File: rtl/mcu_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_block_sequencer_pkg
// Description : Shared types for the 4:2:0 MCU write path. Holds the sample
//               width, the 8x8 block and four-quadrant block types, and the
//               channel encoding used by both the sequencer and the channel
//               buffer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_block_sequencer_pkg;

  // Sample width of one decoded pixel.
  localparam int Q    = 8;
  // Highest channel index (Y, Cb, Cr -> 0..2).
  localparam int CH   = 2;
  localparam int CH_W = $clog2(CH + 1);

  // One 8x8 block, indexed [row][col].
  typedef logic [7:0][7:0][Q-1:0] block_t;
  // Four 8x8 blocks, indexed [quadrant][row][col].
  typedef block_t [3:0] quad_t;

  // Channel encoding shared with the channel buffer.
  typedef enum logic [CH_W-1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ch_e;

endpackage
`default_nettype wire

// File: rtl/chroma_upsample_2x.sv
`default_nettype none
// ============================================================================
// Module      : chroma_upsample_2x
// Description : Purely combinational nearest-neighbour 2x upsampler. Each
//               quadrant of the input 8x8 block is expanded into a full 8x8
//               output block. Quadrant index bit 1 selects the row half and
//               bit 0 the column half (0 TL, 1 TR, 2 BL, 3 BR).
// Ports       : block_in   - 8x8 chroma block
//               blocks_out - four 8x8 quadrant blocks
// Revision    : 1.0 - initial release
// ============================================================================
module chroma_upsample_2x
  import mcu_block_sequencer_pkg::*;
(
  input  block_t block_in,
  output quad_t  blocks_out
);

  // Pure wiring: every output sample is a bit-exact copy of one input sample.
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    for (genvar gr = 0; gr < 8; gr++) begin : g_row
      for (genvar gc = 0; gc < 8; gc++) begin : g_col
        assign blocks_out[gi][gr][gc] =
          block_in[4 * (gi / 2) + gr / 2][4 * (gi % 2) + gc / 2];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcu_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mcu_block_sequencer
// Description : Write-side driver for the MCU channel buffer. Accepts blocks
//               in MCU order Y0..Y3, Cb, Cr; writes each Y block into slot 3
//               of the buffer, upsamples chroma into four quadrant blocks,
//               and holds off upstream while the buffer drains.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               flush         - abandon partial MCU, restart at Y0
//               block_in      - decoded 8x8 block from the IDCT
//               valid_in      - block_in valid
//               ready_out     - block is accepted this cycle when valid_in
//               blocks_out    - registered write data (4 blocks)
//               wr_en         - one-cycle write strobe
//               ch            - channel of the write (0 Y, 1 Cb, 2 Cr)
//               mcu_done      - pulses with the Cr write
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_block_sequencer
  import mcu_block_sequencer_pkg::*;
#(
  // Must be at least 4 so the buffer emits all four triplets first.
  parameter int DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  block_t          block_in,
  input  logic            valid_in,
  output logic            ready_out,
  output quad_t           blocks_out,
  output logic            wr_en,
  output logic [CH_W-1:0] ch,
  output logic            mcu_done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  // The counter holds DRAIN for DRAIN_CYCLES cycles: load N-1, exit at 0.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] ST_Y     = 2'd0;
  localparam logic [1:0] ST_CB    = 2'd1;
  localparam logic [1:0] ST_CR    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       ycnt;
  logic [CNT_W-1:0] drain_cnt;

  logic   accept;
  quad_t  up_quad;
  quad_t  y_quad;
  ch_e    ch_sel;

  chroma_upsample_2x u_upsample (
    .block_in   (block_in),
    .blocks_out (up_quad)
  );

  // ready_out is combinational so reset and flush block the accept in the
  // same cycle they are asserted.
  assign ready_out = (state != ST_DRAIN) && !rst && !flush;
  assign accept    = valid_in && ready_out;

  always_comb begin
    y_quad    = '0;
    y_quad[3] = block_in;
  end

  always_comb begin
    ch_sel = CH_Y;
    case (state)
      ST_CB:   ch_sel = CH_CB;
      ST_CR:   ch_sel = CH_CR;
      default: ch_sel = CH_Y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_Y;
      ycnt       <= '0;
      drain_cnt  <= '0;
      wr_en      <= 1'b0;
      ch         <= CH_Y;
      mcu_done   <= 1'b0;
      blocks_out <= '0;
    end else begin
      if (flush) begin
        state     <= ST_Y;
        ycnt      <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          ST_Y: begin
            if (accept) begin
              ycnt <= ycnt + 2'd1;
              if (ycnt == 2'd3) state <= ST_CB;
            end
          end
          ST_CB: begin
            if (accept) state <= ST_CR;
          end
          ST_CR: begin
            if (accept) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == '0) begin
              state <= ST_Y;
              ycnt  <= '0;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
          default: state <= ST_Y;
        endcase
      end

      // accept already excludes the flush cycle.
      wr_en    <= accept;
      mcu_done <= accept && (state == ST_CR);
      if (accept) begin
        ch         <= ch_sel;
        blocks_out <= (state == ST_Y) ? y_quad : up_quad;
      end else begin
        ch <= CH_Y;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_block_sequencer
// Description : Self-checking bench for mcu_block_sequencer. Expected writes
//               are queued when a block is accepted and compared when the
//               DUT strobes wr_en. A second instance covers DRAIN_CYCLES = 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_block_sequencer;
  import mcu_block_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  block_t          block_in = '0;
  logic            valid_in = 1'b0;
  logic            ready_out;
  quad_t           blocks_out;
  logic            wr_en;
  logic [CH_W-1:0] ch;
  logic            mcu_done;

  logic            flush6 = 1'b0;
  block_t          block6 = '0;
  logic            valid6 = 1'b0;
  logic            ready6;
  quad_t           blocks6;
  logic            wr6;
  logic [CH_W-1:0] ch6;
  logic            done6;

  mcu_block_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .block_in(block_in),
    .valid_in(valid_in), .ready_out(ready_out), .blocks_out(blocks_out),
    .wr_en(wr_en), .ch(ch), .mcu_done(mcu_done)
  );

  mcu_block_sequencer #(.DRAIN_CYCLES(6)) dut6 (
    .clk(clk), .rst(rst), .flush(flush6), .block_in(block6),
    .valid_in(valid6), .ready_out(ready6), .blocks_out(blocks6),
    .wr_en(wr6), .ch(ch6), .mcu_done(done6)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [CH_W-1:0] ch;
    logic            done;
    quad_t           data;
  } exp_t;

  exp_t   sb[$];
  int     n_total = 0;
  int     n_pass  = 0;
  int     cyc     = 0;
  quad_t  last_cb = '0;
  quad_t  last_exp = '0;

  function automatic block_t const_block(input int v);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = Q'(v);
    return b;
  endfunction

  function automatic block_t ramp_block(input int base);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = Q'(base + 8 * r + c);
    return b;
  endfunction

  // Reference layout of one write.
  function automatic quad_t model(input block_t b, input bit is_y);
    quad_t q;
    q = '0;
    if (is_y) begin
      q[3] = b;
    end else begin
      for (int i = 0; i < 4; i++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            q[i][r][c] = b[(i >= 2 ? 4 : 0) + r / 2][(i % 2 == 1 ? 4 : 0) + c / 2];
    end
    return q;
  endfunction

  // Write monitor / scoreboard.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en) begin
      exp_t e;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL spurious_write: wr_en=1 ch=%0d but no write expected", ch);
      end else begin
        e = sb.pop_front();
        if (e.due !== cyc || ch !== e.ch || mcu_done !== e.done || blocks_out !== e.data)
          $display("FAIL write_cmp: cyc=%0d ch=%0d done=%0b, required cyc=%0d ch=%0d done=%0b data_ok=%0b",
                   cyc, ch, mcu_done, e.due, e.ch, e.done, blocks_out === e.data);
        else n_pass++;
        if (e.ch == 2'd1) last_cb = blocks_out;
      end
    end else begin
      n_total++;
      if (ch !== '0 || mcu_done !== 1'b0)
        $display("FAIL idle_outputs: ch=%0d mcu_done=%0b, required 0 0", ch, mcu_done);
      else if (sb.size() > 0 && sb[0].due <= cyc)
        $display("FAIL missing_write: wr_en=0 at cyc %0d, required 1 (ch %0d)", cyc, sb[0].ch);
      else n_pass++;
    end
  end

  // Offer one block, wait for acceptance, queue its expected write.
  task automatic drive(input block_t b, input int c, input bit done);
    int waits = 0;
    exp_t e;
    @(negedge clk);
    block_in = b;
    valid_in = 1'b1;
    #1;
    while (!ready_out && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!ready_out) begin
      n_total++;
      $display("FAIL accept_timeout: ready_out=0 after %0d cycles, required 1", waits);
    end else begin
      e.due  = cyc + 1;
      e.ch   = CH_W'(c);
      e.done = done;
      e.data = model(b, c == 0);
      sb.push_back(e);
      last_exp = e.data;
    end
    @(posedge clk);
    #2;
    valid_in = 1'b0;
  endtask

  task automatic send_mcu(input int ybase);
    for (int k = 0; k < 4; k++) drive(const_block(ybase + k), 0, 1'b0);
    drive(ramp_block(0), 1, 1'b0);
    drive(ramp_block(64), 2, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    valid_in = 1'b1;
    block_in = const_block(9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (ready_out !== 1'b0 || wr_en !== 1'b0 || blocks_out !== '0)
        $display("FAIL reset_state: ready=%0b wr_en=%0b blocks_zero=%0b, required 0 0 1",
                 ready_out, wr_en, blocks_out === '0);
      else n_pass++;
    end
    valid_in = 1'b0;
    rst = 1'b0;
    #1;
    n_total++;
    if (ready_out !== 1'b1) $display("FAIL post_reset_ready: ready=%0b, required 1", ready_out);
    else n_pass++;
  endtask

  task automatic test_full_mcu;
    send_mcu(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (ready_out !== 1'b0) $display("FAIL drain_ready: cycle %0d ready=%0b, required 0", k + 1, ready_out);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (ready_out !== 1'b1) $display("FAIL drain_end: ready=%0b, required 1", ready_out);
    else n_pass++;
    n_total++;
    if (last_cb[3][7][7] !== Q'(63) || last_cb[1][0][1] !== Q'(4) || last_cb[2][1][0] !== Q'(32))
      $display("FAIL cb_spots: [3][7][7]=%0d [1][0][1]=%0d [2][1][0]=%0d, required 63 4 32",
               last_cb[3][7][7], last_cb[1][0][1], last_cb[2][1][0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    send_mcu(10);
    send_mcu(20);
    idle(6);
  endtask

  task automatic test_bubbles;
    drive(const_block(1), 0, 1'b0);
    drive(const_block(2), 0, 1'b0);
    idle(5);
    n_total++;
    if (blocks_out !== last_exp) $display("FAIL output_hold: blocks_out changed while idle, required last write");
    else n_pass++;
    drive(const_block(3), 0, 1'b0);
    drive(const_block(4), 0, 1'b0);
    drive(ramp_block(0), 1, 1'b0);
    idle(2);
    drive(ramp_block(64), 2, 1'b1);
    idle(6);
  endtask

  task automatic test_flush;
    drive(const_block(5), 0, 1'b0);
    drive(const_block(6), 0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    send_mcu(30);
    idle(6);
    // Flush raised together with a valid block: that block must be dropped.
    drive(const_block(7), 0, 1'b0);
    @(negedge clk);
    flush    = 1'b1;
    valid_in = 1'b1;
    block_in = const_block(99);
    #1;
    n_total++;
    if (ready_out !== 1'b0) $display("FAIL flush_ready: ready=%0b, required 0", ready_out);
    else n_pass++;
    @(negedge clk);
    flush    = 1'b0;
    valid_in = 1'b0;
    send_mcu(40);
    idle(6);
  endtask

  task automatic test_drain6;
    int acc = 0;
    int waits = 0;
    @(negedge clk);
    block6 = ramp_block(0);
    valid6 = 1'b1;
    while (acc < 6 && waits < 40) begin
      #1;
      if (ready6) acc++;
      waits++;
      @(negedge clk);
    end
    valid6 = 1'b0;
    n_total++;
    if (acc != 6 || wr6 !== 1'b1 || done6 !== 1'b1 || ch6 !== 2'd2)
      $display("FAIL drain6_cr_write: accepts=%0d wr=%0b done=%0b ch=%0d, required 6 1 1 2",
               acc, wr6, done6, ch6);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (ready6 !== 1'b0) $display("FAIL drain6_ready: cycle %0d ready=%0b, required 0", k + 1, ready6);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (ready6 !== 1'b1) $display("FAIL drain6_end: ready=%0b, required 1", ready6);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_full_mcu;
    test_back_to_back;
    test_bubbles;
    test_flush;
    test_drain6;
    idle(3);
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
